// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: ALU, iterative mult/div with HI/LO, EX/MEM pipeline register
module ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ID_EX_A,
  input  logic [DATA_W-1:0] ID_EX_B,
  input  logic [4:0]        ID_EX_rt,
  input  logic [4:0]        ID_EX_rd,
  input  logic [5:0]        ID_EX_opcode,
  input  logic [DATA_W-1:0] ID_EX_sign_extend_offset,
  input  logic              ID_EX_wb_reg_write,
  input  logic              ID_EX_wb_mem_to_reg,
  input  logic              ID_EX_mem_read,
  input  logic              ID_EX_mem_write,
  input  logic              ID_EX_ex_alu_src_b,
  input  logic              ID_EX_ex_dst_reg_sel,
  input  logic [1:0]        ID_EX_ex_alu_op,
  output logic [DATA_W-1:0] EX_MEM_alu_result,
  output logic [DATA_W-1:0] EX_MEM_B,
  output logic [4:0]        EX_MEM_dst,
  output logic              EX_MEM_wb_reg_write,
  output logic              EX_MEM_wb_mem_to_reg,
  output logic              EX_MEM_mem_read,
  output logic              EX_MEM_mem_write,
  output logic              pstop_o
);
  localparam int W2 = 2 * DATA_W;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] hi_q, lo_q, hi_d, lo_d;
  logic [DATA_W-1:0] rs_q, b_q;
  logic [W2-1:0]     p_q, p_step, prod;
  logic              is_div_q, neg_a_q, neg_b_q, b_zero_q;

  logic [DATA_W-1:0] imm, imm_zx, opb, alu_res, mag_a, mag_b;
  logic [5:0]        funct;
  logic [4:0]        shamt;
  logic              md_op, signed_op, neg_a, neg_b, start, last;
  logic [DATA_W:0]   mul_sum, rem_sh, div_diff;

  assign imm    = ID_EX_sign_extend_offset;
  assign funct  = imm[5:0];
  assign shamt  = imm[10:6];
  assign imm_zx = {{(DATA_W-16){1'b0}}, imm[15:0]};
  assign opb    = ID_EX_ex_alu_src_b ? imm : ID_EX_B;

  always_comb begin
    alu_res = '0;
    case (ID_EX_ex_alu_op)
      2'b00: alu_res = ID_EX_A + opb;
      2'b01: alu_res = ID_EX_A - opb;
      2'b10: begin
        case (funct)
          6'h20, 6'h21: alu_res = ID_EX_A + opb;
          6'h22, 6'h23: alu_res = ID_EX_A - opb;
          6'h24: alu_res = ID_EX_A & opb;
          6'h25: alu_res = ID_EX_A | opb;
          6'h26: alu_res = ID_EX_A ^ opb;
          6'h27: alu_res = ~(ID_EX_A | opb);
          6'h2A: alu_res = {{(DATA_W-1){1'b0}}, $signed(ID_EX_A) < $signed(opb)};
          6'h2B: alu_res = {{(DATA_W-1){1'b0}}, ID_EX_A < opb};
          6'h00: alu_res = opb << shamt;
          6'h02: alu_res = opb >> shamt;
          6'h03: alu_res = $signed(opb) >>> shamt;
          6'h10: alu_res = hi_q;
          6'h12: alu_res = lo_q;
          default: alu_res = '0;
        endcase
      end
      default: begin
        case (ID_EX_opcode)
          6'h08, 6'h09: alu_res = ID_EX_A + imm;
          6'h0A: alu_res = {{(DATA_W-1){1'b0}}, $signed(ID_EX_A) < $signed(imm)};
          6'h0B: alu_res = {{(DATA_W-1){1'b0}}, ID_EX_A < imm};
          6'h0C: alu_res = ID_EX_A & imm_zx;
          6'h0D: alu_res = ID_EX_A | imm_zx;
          6'h0E: alu_res = ID_EX_A ^ imm_zx;
          6'h0F: alu_res = {imm[15:0], 16'h0000};
          default: alu_res = '0;
        endcase
      end
    endcase
  end

  // funct 0x18..0x1B: bit1 selects divide, bit0 selects unsigned
  assign md_op     = (ID_EX_ex_alu_op == 2'b10) && (funct[5:2] == 4'b0110);
  assign signed_op = ~funct[0];
  assign neg_a     = signed_op & ID_EX_A[DATA_W-1];
  assign neg_b     = signed_op & ID_EX_B[DATA_W-1];
  assign mag_a     = neg_a ? -ID_EX_A : ID_EX_A;
  assign mag_b     = neg_b ? -ID_EX_B : ID_EX_B;
  assign start     = (state_q == IDLE) && md_op && !ID_EX_wb_reg_write;
  assign last      = (state_q == BUSY) && (cnt_q == 5'd31);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = BUSY;
        cnt_d   = '0;
      end
      default: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = IDLE;
      end
    endcase
  end

  assign pstop_o = rst & (start || ((state_q == BUSY) && (cnt_q != 5'd31)));

  // p_q holds {upper, lower}: product accumulator + multiplier, or remainder + quotient
  assign mul_sum  = {1'b0, p_q[W2-1:DATA_W]} + (p_q[0] ? {1'b0, b_q} : '0);
  assign rem_sh   = p_q[W2-1:DATA_W-1];
  assign div_diff = rem_sh - {1'b0, b_q};
  assign p_step   = !is_div_q        ? {mul_sum, p_q[DATA_W-1:1]}
                  : div_diff[DATA_W] ? {rem_sh[DATA_W-1:0], p_q[DATA_W-2:0], 1'b0}
                  :                    {div_diff[DATA_W-1:0], p_q[DATA_W-2:0], 1'b1};
  assign prod     = (neg_a_q ^ neg_b_q) ? -p_step : p_step;

  always_comb begin
    hi_d = prod[W2-1:DATA_W];
    lo_d = prod[DATA_W-1:0];
    if (is_div_q) begin
      if (b_zero_q) begin
        lo_d = '1;
        hi_d = rs_q;
      end else begin
        lo_d = (neg_a_q ^ neg_b_q) ? -p_step[DATA_W-1:0] : p_step[DATA_W-1:0];
        hi_d = neg_a_q ? -p_step[W2-1:DATA_W] : p_step[W2-1:DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q              <= IDLE;
      cnt_q                <= '0;
      hi_q                 <= '0;
      lo_q                 <= '0;
      rs_q                 <= '0;
      b_q                  <= '0;
      p_q                  <= '0;
      is_div_q             <= 1'b0;
      neg_a_q              <= 1'b0;
      neg_b_q              <= 1'b0;
      b_zero_q             <= 1'b0;
      EX_MEM_alu_result    <= '0;
      EX_MEM_B             <= '0;
      EX_MEM_dst           <= '0;
      EX_MEM_wb_reg_write  <= 1'b0;
      EX_MEM_wb_mem_to_reg <= 1'b0;
      EX_MEM_mem_read      <= 1'b0;
      EX_MEM_mem_write     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start) begin
        rs_q     <= ID_EX_A;
        b_q      <= mag_b;
        p_q      <= {{DATA_W{1'b0}}, mag_a};
        is_div_q <= funct[1];
        neg_a_q  <= neg_a;
        neg_b_q  <= neg_b;
        b_zero_q <= (ID_EX_B == '0);
      end else if (state_q == BUSY) begin
        p_q <= p_step;
      end
      if (last) begin
        hi_q <= hi_d;
        lo_q <= lo_d;
      end
      if (pstop_o) begin
        EX_MEM_wb_reg_write  <= 1'b0;
        EX_MEM_wb_mem_to_reg <= 1'b0;
        EX_MEM_mem_read      <= 1'b0;
        EX_MEM_mem_write     <= 1'b0;
      end else begin
        EX_MEM_alu_result    <= alu_res;
        EX_MEM_B             <= ID_EX_B;
        EX_MEM_dst           <= ID_EX_ex_dst_reg_sel ? ID_EX_rd : ID_EX_rt;
        EX_MEM_wb_reg_write  <= ID_EX_wb_reg_write;
        EX_MEM_wb_mem_to_reg <= ID_EX_wb_mem_to_reg;
        EX_MEM_mem_read      <= ID_EX_mem_read;
        EX_MEM_mem_write     <= ID_EX_mem_write;
      end
    end
  end
endmodule
